// File: rtl/uc_cuenta_unos_pkg.sv
// Shared definitions for the ones-count control unit: state encodings and
// counter sizing helper.
package uc_cuenta_unos_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        TEST  = 3'd2,
        ADD   = 3'd3,
        SHIFT = 3'd4,
        DONE  = 3'd5
    } estado_t;

    function automatic int cnt_width(input int ancho);
        return $clog2(ancho + 1);
    endfunction

endpackage

// File: rtl/uc_cuenta_unos_contador.sv
// Iteration counter: loaded with ANCHO, decremented once per shift,
// flags when it holds 1 so the sequencer can exit before it would wrap.
module contador_iter
    import uc_cuenta_unos_pkg::*;
#(
    parameter int ANCHO = 3
) (
    input  logic clk,
    input  logic reset,
    input  logic carga,
    input  logic dec,
    output logic uno
);

    localparam int CW = cnt_width(ANCHO);
    localparam logic [CW-1:0] CARGA_VAL = CW'(ANCHO);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (carga) begin
            cnt_d = CARGA_VAL;
        end else if (dec && (cnt_q != '0)) begin
            cnt_d = cnt_q - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign uno = (cnt_q == CW'(1));

endmodule

// File: rtl/uc_cuenta_unos.sv
// Moore sequencer for the ones-count datapath: load, test Q[0], add, shift,
// repeated ANCHO times, then flag completion on fin.
module uc_cuenta_unos
    import uc_cuenta_unos_pkg::*;
#(
    parameter int ANCHO = 3
) (
    input  logic clk,
    input  logic reset,
    input  logic start,
    input  logic q0,
    output logic borra_a,
    output logic carga_q,
    output logic carga_a,
    output logic desplaza_q,
    output logic ocupado,
    output logic fin
);

    estado_t state_q, state_d;
    logic    fin_q, fin_d;
    logic    cnt_uno;

    contador_iter #(
        .ANCHO(ANCHO)
    ) u_contador (
        .clk   (clk),
        .reset (reset),
        .carga (state_q == LOAD),
        .dec   (state_q == SHIFT),
        .uno   (cnt_uno)
    );

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (start) state_d = LOAD;
            LOAD:    state_d = TEST;
            TEST:    state_d = q0 ? ADD : SHIFT;
            ADD:     state_d = SHIFT;
            SHIFT:   state_d = cnt_uno ? DONE : TEST;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // fin survives the return to IDLE and is only dropped when a new run starts
    always_comb begin
        fin_d = fin_q;
        if (state_d == DONE) begin
            fin_d = 1'b1;
        end else if (state_d == LOAD) begin
            fin_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            fin_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            fin_q   <= fin_d;
        end
    end

    always_comb begin
        borra_a    = 1'b0;
        carga_q    = 1'b0;
        carga_a    = 1'b0;
        desplaza_q = 1'b0;
        ocupado    = 1'b1;
        case (state_q)
            IDLE:  ocupado = 1'b0;
            LOAD: begin
                borra_a = 1'b1;
                carga_q = 1'b1;
            end
            ADD:   carga_a = 1'b1;
            SHIFT: desplaza_q = 1'b1;
            default: ;
        endcase
    end

    assign fin = fin_q;

endmodule
